// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter that runs a 4-bit AND/XOR operation for the granted
// requester over a configurable number of execute cycles.
//
// state | meaning
// IDLE  | waiting for req0/req1, picks the winner
// GRANT | gnt pulse to the winner, operands latched at end of cycle
// EXEC  | down-counter runs; result registered when it reaches zero
// DONE  | valid pulse to the winner, then back to IDLE
module logic_unit_arbiter #(
  parameter int EXEC_CYCLES = 1,
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       op0,
  input  logic       op1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] result,
  output logic       valid0,
  output logic       valid1,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GRANT, EXEC, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       winner;
  logic       last_served;
  logic       op_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       pick;

  // On a tie in round-robin mode the requester not served last wins.
  always_comb begin
    pick = ~req0;
    if (ROUND_ROBIN != 0 && req0 && req1) pick = ~last_served;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      result      <= 4'd0;
      last_served <= 1'b1;
      winner      <= 1'b0;
      op_q        <= 1'b0;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      valid0      <= 1'b0;
      valid1      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state  <= GRANT;
            winner <= pick;
            gnt0   <= ~pick;
            gnt1   <= pick;
            busy   <= 1'b1;
          end
        end
        GRANT: begin
          state       <= EXEC;
          gnt0        <= 1'b0;
          gnt1        <= 1'b0;
          op_q        <= winner ? op1 : op0;
          a_q         <= winner ? a1 : a0;
          b_q         <= winner ? b1 : b0;
          last_served <= winner;
          cnt         <= CNT_LOAD;
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            state  <= DONE;
            result <= op_q ? (a_q ^ b_q) : (a_q & b_q);
            valid0 <= ~winner;
            valid1 <= winner;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          valid0 <= 1'b0;
          valid1 <= 1'b0;
          busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: three parameterisations share one stimulus
// stream and are compared every cycle against a transaction-timeline model.
module tb_logic_unit_arbiter;

  logic       clk = 1'b0;
  logic       rst_n, req0, req1, op0, op1;
  logic [3:0] a0, b0, a1, b1;

  wire  [2:0] gnt0_w, gnt1_w, valid0_w, valid1_w, busy_w;
  wire  [3:0] res_w [3];

  localparam int NC  [3] = '{1, 4, 1};
  localparam int RRP [3] = '{1, 1, 0};

  always #5 clk = ~clk;

  logic_unit_arbiter #(.EXEC_CYCLES(1), .ROUND_ROBIN(1)) u_d (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0_w[0]), .gnt1(gnt1_w[0]),
    .result(res_w[0]), .valid0(valid0_w[0]), .valid1(valid1_w[0]), .busy(busy_w[0]));

  logic_unit_arbiter #(.EXEC_CYCLES(4), .ROUND_ROBIN(1)) u_4 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0_w[1]), .gnt1(gnt1_w[1]),
    .result(res_w[1]), .valid0(valid0_w[1]), .valid1(valid1_w[1]), .busy(busy_w[1]));

  logic_unit_arbiter #(.EXEC_CYCLES(1), .ROUND_ROBIN(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0_w[2]), .gnt1(gnt1_w[2]),
    .result(res_w[2]), .valid0(valid0_w[2]), .valid1(valid1_w[2]), .busy(busy_w[2]));

  // Model: an operation is a timeline anchored at the edge where the request
  // was accepted; everything else is offsets from that edge.
  bit         m_busy  [3];
  int         m_start [3];
  bit         m_owner [3];
  bit         m_last  [3];
  bit         m_op    [3];
  logic [3:0] m_a [3], m_b [3], m_res [3];
  int         cyc;
  int         passed, total;
  int         order_d[$], order_fp[$];
  int         gnt1_seen;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      $error("%s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [8:0] e, o;
    bit w;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_busy[i] = 0; m_last[i] = 1; m_res[i] = 4'd0;
      end else if (!m_busy[i]) begin
        if (req0 || req1) begin
          if (RRP[i] != 0 && req0 && req1) w = !m_last[i];
          else w = !req0;
          m_busy[i] = 1; m_start[i] = cyc; m_owner[i] = w;
        end
      end else begin
        if (cyc == m_start[i] + 1) begin
          m_op[i] = m_owner[i] ? op1 : op0;
          m_a[i]  = m_owner[i] ? a1 : a0;
          m_b[i]  = m_owner[i] ? b1 : b0;
          m_last[i] = m_owner[i];
        end
        if (cyc == m_start[i] + 1 + NC[i])
          m_res[i] = m_op[i] ? (m_a[i] ^ m_b[i]) : (m_a[i] & m_b[i]);
        if (cyc == m_start[i] + 2 + NC[i]) m_busy[i] = 0;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      e = {m_busy[i] && cyc == m_start[i] && !m_owner[i],
           m_busy[i] && cyc == m_start[i] && m_owner[i],
           m_busy[i] && cyc == m_start[i] + 1 + NC[i] && !m_owner[i],
           m_busy[i] && cyc == m_start[i] + 1 + NC[i] && m_owner[i],
           m_busy[i], m_res[i]};
      o = {gnt0_w[i], gnt1_w[i], valid0_w[i], valid1_w[i], busy_w[i], res_w[i]};
      check($sformatf("model_u%0d", i), o, e);
    end
    if (gnt0_w[0]) order_d.push_back(0);
    if (gnt1_w[0]) order_d.push_back(1);
    if (gnt0_w[2]) order_fp.push_back(0);
    if (gnt1_w[2]) order_fp.push_back(1);
    if (gnt1_w[0] || gnt1_w[1]) gnt1_seen++;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    passed = 0; total = 0; cyc = 0; gnt1_seen = 0;
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 0; m_start[i] = 0; m_owner[i] = 0; m_last[i] = 1;
      m_op[i] = 0; m_a[i] = 0; m_b[i] = 0; m_res[i] = 0;
    end
    rst_n = 1'b0; req0 = 0; req1 = 0; op0 = 0; op1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    run(2);
    check("reset_outputs", {gnt0_w[0], gnt1_w[0], valid0_w[0], valid1_w[0], busy_w[0], res_w[0]}, 9'd0);

    // AND on requester 0
    rst_n = 1'b1; req1 = 1'b0; op0 = 1'b0; a0 = 4'b1100; b0 = 4'b1010;
    step();
    check("and_gnt", {7'd0, gnt0_w[0], gnt1_w[0]}, 9'b10);
    req0 = 1'b0;
    step();
    check("and_busy", {8'd0, busy_w[0]}, 9'd1);
    step();
    check("and_done", {3'd0, valid0_w[0], valid1_w[0], res_w[0]}, {3'd0, 2'b10, 4'b1000});
    run(7);

    // XOR on requester 1
    req1 = 1'b1; op1 = 1'b1; a1 = 4'b1100; b1 = 4'b1010;
    step();
    check("xor_gnt", {7'd0, gnt0_w[0], gnt1_w[0]}, 9'b01);
    req1 = 1'b0;
    run(2);
    check("xor_done", {3'd0, valid0_w[0], valid1_w[0], res_w[0]}, {3'd0, 2'b01, 4'b0110});
    run(7);

    // Continuous tie: alternation vs fixed priority
    reset_pulse();
    order_d.delete(); order_fp.delete();
    req0 = 1'b1; req1 = 1'b1;
    run(16);
    req0 = 1'b0; req1 = 1'b0;
    run(8);
    check("rr_count", 9'(order_d.size() >= 4), 9'd1);
    check("fp_count", 9'(order_fp.size() >= 4), 9'd1);
    if (order_d.size() >= 4 && order_fp.size() >= 4) begin
      check("rr_order", {5'd0, 1'(order_d[0]), 1'(order_d[1]), 1'(order_d[2]), 1'(order_d[3])}, 9'b0101);
      check("fp_order", {5'd0, 1'(order_fp[0]), 1'(order_fp[1]), 1'(order_fp[2]), 1'(order_fp[3])}, 9'b0000);
    end

    // Long execute, operand change after grant
    reset_pulse();
    req0 = 1'b1; op0 = 1'b1; a0 = 4'b1111; b0 = 4'b0101;
    step();
    req0 = 1'b0;
    step();
    a0 = 4'b0000;
    run(4);
    check("exec4_done", {3'd0, valid0_w[1], valid1_w[1], res_w[1]}, {3'd0, 2'b10, 4'b1010});
    run(4);

    // Reset in the middle of execute
    reset_pulse();
    req0 = 1'b1; op0 = 1'b0; a0 = 4'b1111; b0 = 4'b1111;
    step();
    req0 = 1'b0;
    run(2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_state", {4'd0, busy_w[1], res_w[1]}, 9'd0);
    run(6);
    check("abort_result", {5'd0, res_w[1]}, 9'd0);
    req0 = 1'b1; req1 = 1'b1;
    step();
    check("abort_tie", {7'd0, gnt0_w[1], gnt1_w[1]}, 9'b10);
    req0 = 1'b0; req1 = 1'b0;
    run(8);

    // Request only while busy is never granted
    gnt1_seen = 0;
    req0 = 1'b1;
    step();
    req0 = 1'b0; req1 = 1'b1;
    run(2);
    req1 = 1'b0;
    run(10);
    check("busy_drop", 9'(gnt1_seen), 9'd0);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      req0 = ($urandom_range(0, 2) == 0);
      req1 = ($urandom_range(0, 2) == 0);
      op0 = 1'($urandom); op1 = 1'($urandom);
      a0 = 4'($urandom); b0 = 4'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter EXEC_CYCLES, default 1; execute-phase length in cycles; legal range 1..15.
REQ-002 Parameter ROUND_ROBIN, default 1; 1 = round-robin, 0 = fixed priority with requester 0 winning.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req0, req1  input  1 each  operation request from requester 0 or 1.
REQ-006 op0, op1  input  1 each  opcode: 0 = bitwise AND, 1 = bitwise XOR.
REQ-007 a0, b0, a1, b1  input  4 each  operands, bit 3 = MSB.
REQ-008 gnt0, gnt1  output  1 each  grant pulse; operands sampled on this cycle.
REQ-009 result  output  4  registered result of the last completed operation.
REQ-010 valid0, valid1  output  1 each  one-cycle completion pulse to the owning requester.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 FSM states: IDLE, GRANT, EXEC, DONE; exactly one state is active at a time.
REQ-013 IDLE: if req0 or req1 is sampled high, go to GRANT. The winner is recorded per REQ-017/018. Otherwise stay in IDLE.
REQ-014 GRANT: lasts one cycle; assert gnt of the winner only; latch its op, a and b into internal registers at the end of the cycle; go to EXEC.
REQ-015 EXEC: a 4-bit down-counter loaded with EXEC_CYCLES-1 on entry; stay while counter != 0, decrementing each cycle; on the cycle counter == 0, register result and go to DONE.
REQ-016 Result: latched a AND latched b when latched op = 0; latched a XOR latched b when op = 1; computed per bit, no carries.
REQ-017 ROUND_ROBIN=1: single requester wins. If both are high, the requester not served last wins. A last-served pointer updates in GRANT.
REQ-018 ROUND_ROBIN=0: req0 wins whenever high; the pointer is unused.
REQ-019 DONE: lasts one cycle; assert valid of the granted requester only; go to IDLE.
REQ-020 Latency, EXEC_CYCLES=N: req sampled in IDLE at edge k gives gnt high in cycle k+1, result/valid in cycle k+2+N, and IDLE again in cycle k+3+N.
REQ-021 Requests are sampled only in IDLE. Requests asserted while busy are neither queued nor lost; they are re-evaluated on return to IDLE.
REQ-022 Requesters hold req, op, a and b stable until gnt. A req dropped before being sampled in IDLE is ignored.
REQ-023 Operand changes after gnt do not affect the result.
REQ-024 result holds its value from DONE until the next DONE; it does not change in IDLE, GRANT or EXEC.
REQ-025 At most one of gnt0/gnt1 is high in any cycle; the same applies to valid0/valid1. gnt and valid are never high in the same cycle.
REQ-026 The pointer records only the last-served requester. Back-to-back continuous requests from both alternate 0,1,0,1.

Reset
REQ-027 rst_n low at a rising edge forces IDLE, counter = 0, result = 4'b0000, pointer = "1 served last" (so req0 wins the first tie), and gnt0 = gnt1 = valid0 = valid1 = busy = 0. This holds from the next cycle.
REQ-028 Reset mid-operation (GRANT, EXEC or DONE) aborts the operation: no valid pulse is issued and result does not update.
REQ-029 Outputs remain at reset values while rst_n is low, regardless of req inputs.

Verification
REQ-030 Default parameters; req0=1, op0=0, a0=4'b1100, b0=4'b1010 -> gnt0 in cycle 1, result=4'b1000 with valid0 in cycle 3, busy high in cycles 1-3.
REQ-031 req1=1, op1=1, a1=4'b1100, b1=4'b1010 -> gnt1 only, result=4'b0110 with valid1 only, valid0 stays 0.
REQ-032 After reset, req0 and req1 held high together, ROUND_ROBIN=1 -> grant order 0,1,0,1; with ROUND_ROBIN=0 -> 0,0,0,0.
REQ-033 EXEC_CYCLES=4, req0 with a0=4'b1111, b0=4'b0101, op0=1 -> valid0 in cycle 6, result=4'b1010. Change a0 to 4'b0000 in cycle 2 -> result unchanged.
REQ-034 rst_n low for one cycle during EXEC (EXEC_CYCLES=4) -> no valid pulse, result stays at prior value 4'b0000, FSM in IDLE, next tie grants req0.
REQ-035 req1 pulsed high only while busy, then dropped before IDLE -> never granted, no valid1.
